// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined integer ALU: the op-code width and the
// op-code constants used by alu_core and alu_pipe.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd4;
   localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
   localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;
   localparam logic [ALU_OP_W-1:0] ALU_EQ   = 4'd10;
   localparam logic [ALU_OP_W-1:0] ALU_NE   = 4'd11;
   localparam logic [ALU_OP_W-1:0] ALU_GE   = 4'd12;
   localparam logic [ALU_OP_W-1:0] ALU_GEU  = 4'd13;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath.
//   op     : operation code (alu_pkg constants); unused codes yield 0
//   a, b   : operands, XLEN bits
//   result : XLEN-bit result; compares return 0/1 zero-extended
// ---------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [ALU_OP_W-1:0] op,
   input  logic [XLEN-1:0]     a,
   input  logic [XLEN-1:0]     b,
   output logic [XLEN-1:0]     result
);

   localparam int SH_W = $clog2(XLEN);

   logic [SH_W-1:0] shamt;
   logic            lt_s;
   logic            lt_u;
   logic            eq;

   // Only the low log2(XLEN) bits of b select the shift distance.
   assign shamt = b[SH_W-1:0];
   assign lt_s  = $signed(a) < $signed(b);
   assign lt_u  = a < b;
   assign eq    = a == b;

   always_comb begin
      // NOTE: default assigned first so every path drives result; no latch.
      result = '0;
      unique case (op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
         ALU_EQ:   result = {{(XLEN-1){1'b0}}, eq};
         ALU_NE:   result = {{(XLEN-1){1'b0}}, !eq};
         ALU_GE:   result = {{(XLEN-1){1'b0}}, !lt_s};
         ALU_GEU:  result = {{(XLEN-1){1'b0}}, !lt_u};
         default:  result = '0;
      endcase
   end

endmodule : alu_core

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Pipelined integer ALU between the ALU reservation station and the CDB.
// One op per cycle with valid/ready on both sides, 1- or 2-stage latency.
//   clk, reset    : clock, asynchronous active-low reset
//   rdy           : global enable; low freezes every register
//   flush         : drops every in-flight op (and a same-cycle input)
//   in_*          : issue side (op, operands, ROB tag, valid/ready)
//   out_*         : result side toward the CDB (result, tag, valid/ready)
//   done_cnt      : wrapping count of results accepted by the CDB
// ---------------------------------------------------------------------------
module alu_pipe
   import alu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ROB_WIDTH = 4,
   parameter int LATENCY   = 1,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rdy,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ALU_OP_W-1:0]  in_op,
   input  logic [XLEN-1:0]      in_a,
   input  logic [XLEN-1:0]      in_b,
   input  logic [ROB_WIDTH-1:0] in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_result,
   output logic [ROB_WIDTH-1:0] out_tag,
   output logic [CNT_WIDTH-1:0] done_cnt
);

   logic                 in_fire;
   logic                 out_fire;
   logic [ALU_OP_W-1:0]  core_op;
   logic [XLEN-1:0]      core_a;
   logic [XLEN-1:0]      core_b;
   logic [XLEN-1:0]      core_result;
   logic                 out_valid_q;
   logic [XLEN-1:0]      out_result_q;
   logic [ROB_WIDTH-1:0] out_tag_q;
   logic [CNT_WIDTH-1:0] done_cnt_q;

   // in_ready already contains rdy, so both fire terms are rdy-qualified.
   assign in_fire  = in_valid & in_ready;
   assign out_fire = rdy & out_valid_q & out_ready;

   alu_core #(.XLEN(XLEN)) u_core (
      .op     (core_op),
      .a      (core_a),
      .b      (core_b),
      .result (core_result)
   );

   generate
      if (LATENCY == 1) begin : g_lat1
         assign core_op  = in_op;
         assign core_a   = in_a;
         assign core_b   = in_b;
         assign in_ready = rdy & (!out_valid_q | out_ready);

         // Output data only loads on in_fire, which cannot happen while a
         // result is stalled, so a stalled result is held stable.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               out_valid_q  <= 1'b0;
               out_result_q <= '0;
               out_tag_q    <= '0;
            end else if (rdy) begin
               // NOTE: sequential state uses non-blocking assignments only.
               if (flush) begin
                  out_valid_q <= 1'b0;
               end else if (in_fire) begin
                  out_valid_q  <= 1'b1;
                  out_result_q <= core_result;
                  out_tag_q    <= in_tag;
               end else if (out_fire) begin
                  out_valid_q <= 1'b0;
               end
            end
         end
      end else if (LATENCY == 2) begin : g_lat2
         logic                 s1_valid;
         logic [ALU_OP_W-1:0]  s1_op;
         logic [XLEN-1:0]      s1_a;
         logic [XLEN-1:0]      s1_b;
         logic [ROB_WIDTH-1:0] s1_tag;
         logic                 s2_adv;
         logic                 s1_free;

         // Stage 2 moves when empty or drained; stage 1 can take a new op
         // when empty or when its contents move on (bubble compression).
         assign s2_adv   = !out_valid_q | out_ready;
         assign s1_free  = !s1_valid | s2_adv;
         assign in_ready = rdy & s1_free;
         assign core_op  = s1_op;
         assign core_a   = s1_a;
         assign core_b   = s1_b;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               s1_valid     <= 1'b0;
               s1_op        <= '0;
               s1_a         <= '0;
               s1_b         <= '0;
               s1_tag       <= '0;
               out_valid_q  <= 1'b0;
               out_result_q <= '0;
               out_tag_q    <= '0;
            end else if (rdy) begin
               if (flush) begin
                  s1_valid    <= 1'b0;
                  out_valid_q <= 1'b0;
               end else begin
                  if (s2_adv) begin
                     out_valid_q <= s1_valid;
                     if (s1_valid) begin
                        out_result_q <= core_result;
                        out_tag_q    <= s1_tag;
                     end
                  end
                  if (s1_free) begin
                     s1_valid <= in_valid;
                     if (in_valid) begin
                        s1_op  <= in_op;
                        s1_a   <= in_a;
                        s1_b   <= in_b;
                        s1_tag <= in_tag;
                     end
                  end
               end
            end
         end
      end else begin : g_bad_latency
         $error("alu_pipe: LATENCY must be 1 or 2");
      end
   endgenerate

   // Results accepted in a flush cycle still count: flush is not checked here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_cnt_q <= '0;
      end else if (out_fire) begin
         done_cnt_q <= done_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;
   assign done_cnt   = done_cnt_q;

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
// Directed bench for alu_pipe. Instance dut_a is LATENCY=1 with a 4-bit
// counter (wrap case); dut_b is LATENCY=2 with a 16-bit counter. Operand,
// op, tag, rdy and flush are shared; valid/ready are per instance.
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        rdy;
   logic        flush;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_tag;

   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic [31:0] out_result_a;
   logic [3:0]  out_tag_a;
   logic [3:0]  done_cnt_a;

   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic [31:0] out_result_b;
   logic [3:0]  out_tag_b;
   logic [15:0] done_cnt_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_pipe #(.XLEN(32), .ROB_WIDTH(4), .LATENCY(1), .CNT_WIDTH(4)) dut_a (
      .clk(clk), .reset(reset), .rdy(rdy), .flush(flush),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_result(out_result_a), .out_tag(out_tag_a), .done_cnt(done_cnt_a)
   );

   alu_pipe #(.XLEN(32), .ROB_WIDTH(4), .LATENCY(2), .CNT_WIDTH(16)) dut_b (
      .clk(clk), .reset(reset), .rdy(rdy), .flush(flush),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_result(out_result_b), .out_tag(out_tag_b), .done_cnt(done_cnt_b)
   );

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic reset_dut();
      in_valid_a  = 1'b0;
      in_valid_b  = 1'b0;
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
      flush       = 1'b0;
      rdy         = 1'b1;
      reset       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Issue one op to both instances with the CDB stalled, check both
   // results once each pipe has delivered, then drain one cycle.
   task automatic run_op(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input logic [31:0] exp);
      in_op       = op;
      in_a        = a;
      in_b        = b;
      in_tag      = tag;
      in_valid_a  = 1'b1;
      in_valid_b  = 1'b1;
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
      @(negedge clk);
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      @(negedge clk);
      check({name, "_res_a"}, 64'(out_result_a), 64'(exp));
      check({name, "_tag_a"}, 64'(out_tag_a), 64'(tag));
      check({name, "_res_b"}, 64'(out_result_b), 64'(exp));
      check({name, "_tag_b"}, 64'(out_tag_b), 64'(tag));
      out_ready_a = 1'b1;
      out_ready_b = 1'b1;
      @(negedge clk);
      out_ready_a = 1'b0;
      out_ready_b = 1'b0;
   endtask

   initial begin
      int next_tag;
      int got_n;
      int seen;
      int acc;
      int fired;
      logic saw_stall;

      // ---- reset held low with a valid input present ----
      reset = 1'b0; rdy = 1'b1; flush = 1'b0;
      in_valid_a = 1'b1; in_valid_b = 1'b1;
      out_ready_a = 1'b1; out_ready_b = 1'b1;
      in_op = ALU_ADD; in_a = 32'd5; in_b = 32'd7; in_tag = 4'd3;
      repeat (3) @(negedge clk);
      check("rst_valid_a",  64'(out_valid_a),  64'h0);
      check("rst_valid_b",  64'(out_valid_b),  64'h0);
      check("rst_result_a", 64'(out_result_a), 64'h0);
      check("rst_result_b", 64'(out_result_b), 64'h0);
      check("rst_cnt_a",    64'(done_cnt_a),   64'h0);
      check("rst_cnt_b",    64'(done_cnt_b),   64'h0);

      // ---- first op after release: ADD 5,7 tag 3 ----
      out_ready_a = 1'b0; out_ready_b = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      check("first_valid_a_l1",  64'(out_valid_a),  64'h1);
      check("first_result_a",    64'(out_result_a), 64'd12);
      check("first_tag_a",       64'(out_tag_a),    64'd3);
      check("first_valid_b_l1",  64'(out_valid_b),  64'h0);
      @(negedge clk);
      check("first_valid_b_l2",  64'(out_valid_b),  64'h1);
      check("first_result_b",    64'(out_result_b), 64'd12);
      check("first_tag_b",       64'(out_tag_b),    64'd3);
      out_ready_a = 1'b1; out_ready_b = 1'b1;
      @(negedge clk);
      out_ready_a = 1'b0; out_ready_b = 1'b0;
      check("first_cnt_a", 64'(done_cnt_a), 64'd1);
      check("first_cnt_b", 64'(done_cnt_b), 64'd1);

      // ---- op sweep ----
      run_op("sub",  ALU_SUB,  32'h8000_0000, 32'd1,  4'd1, 32'h7FFF_FFFF);
      run_op("sra",  ALU_SRA,  32'h8000_0000, 32'd1,  4'd2, 32'hC000_0000);
      run_op("srl",  ALU_SRL,  32'h8000_0000, 32'd1,  4'd3, 32'h4000_0000);
      run_op("slt",  ALU_SLT,  32'h8000_0000, 32'd1,  4'd4, 32'd1);
      run_op("sltu", ALU_SLTU, 32'h8000_0000, 32'd1,  4'd5, 32'd0);
      run_op("ge",   ALU_GE,   32'h8000_0000, 32'd1,  4'd6, 32'd0);
      run_op("geu",  ALU_GEU,  32'h8000_0000, 32'd1,  4'd7, 32'd1);
      run_op("sll",  ALU_SLL,  32'h8000_0000, 32'd33, 4'd8, 32'd0);
      run_op("sll3", ALU_SLL,  32'h0000_0001, 32'd35, 4'd8, 32'd8);
      run_op("eq",   ALU_EQ,   32'd4,         32'd4,  4'd9, 32'd1);
      run_op("ne",   ALU_NE,   32'd4,         32'd5,  4'd10, 32'd1);
      run_op("and",  ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 4'd11, 32'h0000_F000);
      run_op("or",   ALU_OR,   32'h0000_F0F0, 32'h0000_FF00, 4'd12, 32'h0000_FFF0);
      run_op("xor",  ALU_XOR,  32'h0000_F0F0, 32'h0000_FF00, 4'd13, 32'h0000_0FF0);
      run_op("addw", ALU_ADD,  32'hFFFF_FFFF, 32'd2,  4'd14, 32'd1);
      run_op("op15", 4'd15,    32'h1234_5678, 32'd9,  4'd15, 32'd0);

      // ---- backpressure stream on the 2-stage pipe ----
      reset_dut();
      next_tag = 0; got_n = 0; saw_stall = 1'b0;
      for (int cyc = 0; cyc < 40 && got_n < 6; cyc++) begin
         out_ready_b = !(cyc >= 4 && cyc < 7);
         in_valid_b  = (next_tag < 6);
         in_op  = ALU_ADD;
         in_a   = 32'(next_tag);
         in_b   = 32'd100;
         in_tag = 4'(next_tag);
         #1;
         if (in_valid_b && !in_ready_b) saw_stall = 1'b1;
         if (out_valid_b && out_ready_b) begin
            check("stream_tag",    64'(out_tag_b),    64'(got_n));
            check("stream_result", 64'(out_result_b), 64'(got_n + 100));
            got_n++;
         end
         if (in_valid_b && in_ready_b) next_tag++;
         @(negedge clk);
      end
      in_valid_b = 1'b0;
      check("stream_count",   64'(got_n),       64'd6);
      check("stream_stalled", 64'(saw_stall),   64'h1);
      check("stream_cnt_b",   64'(done_cnt_b),  64'd6);
      check("stream_empty",   64'(out_valid_b), 64'h0);

      // ---- flush with two ops in flight plus a new input ----
      reset_dut();
      in_op = ALU_ADD; in_a = 32'd1; in_b = 32'd1;
      in_tag = 4'd1; in_valid_b = 1'b1;
      @(negedge clk);
      in_tag = 4'd2;
      @(negedge clk);
      in_tag = 4'd3; flush = 1'b1;
      #1;
      check("pre_flush_valid", 64'(out_valid_b), 64'h1);
      @(negedge clk);
      flush = 1'b0; in_valid_b = 1'b0;
      check("post_flush_valid", 64'(out_valid_b), 64'h0);
      out_ready_b = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid_b) seen++;
      end
      check("flush_ghosts", 64'(seen), 64'd0);
      in_op = ALU_ADD; in_a = 32'd20; in_b = 32'd22; in_tag = 4'd7;
      in_valid_b = 1'b1;
      @(negedge clk);
      in_valid_b = 1'b0;
      for (int i = 0; i < 5 && !out_valid_b; i++) @(negedge clk);
      check("after_flush_valid",  64'(out_valid_b),  64'h1);
      check("after_flush_tag",    64'(out_tag_b),    64'd7);
      check("after_flush_result", 64'(out_result_b), 64'd42);
      @(negedge clk);
      check("after_flush_cnt", 64'(done_cnt_b), 64'd1);

      // ---- rdy low freezes a pending result ----
      reset_dut();
      in_op = ALU_XOR; in_a = 32'hF0; in_b = 32'hFF; in_tag = 4'd5;
      in_valid_b = 1'b1;
      @(negedge clk);
      in_valid_b = 1'b0;
      @(negedge clk);
      check("rdy_pre_valid", 64'(out_valid_b), 64'h1);
      rdy = 1'b0; out_ready_b = 1'b1;
      in_valid_b = 1'b1; in_op = ALU_ADD; in_tag = 4'd6;
      #1;
      check("rdy_in_ready", 64'(in_ready_b), 64'h0);
      repeat (4) begin
         @(negedge clk);
         check("rdy_hold_valid",  64'(out_valid_b),  64'h1);
         check("rdy_hold_result", 64'(out_result_b), 64'h0F);
         check("rdy_hold_tag",    64'(out_tag_b),    64'd5);
         check("rdy_hold_cnt",    64'(done_cnt_b),   64'd0);
         check("rdy_hold_ready",  64'(in_ready_b),   64'h0);
      end
      rdy = 1'b1; in_valid_b = 1'b0;
      @(negedge clk);
      check("rdy_resume_cnt",   64'(done_cnt_b),  64'd1);
      check("rdy_resume_valid", 64'(out_valid_b), 64'h0);

      // ---- 4-bit counter wrap on the 1-stage pipe ----
      reset_dut();
      acc = 0; fired = 0;
      out_ready_a = 1'b1;
      for (int cyc = 0; cyc < 60 && fired < 17; cyc++) begin
         in_valid_a = (acc < 17);
         in_op  = ALU_ADD;
         in_a   = 32'(acc);
         in_b   = 32'd0;
         in_tag = 4'(acc);
         #1;
         if (out_valid_a && out_ready_a) begin
            if (fired == 16) check("wrap_cnt_at_16", 64'(done_cnt_a), 64'd0);
            fired++;
         end
         if (in_valid_a && in_ready_a) acc++;
         @(negedge clk);
      end
      in_valid_a = 1'b0;
      check("wrap_fired",   64'(fired),      64'd17);
      check("wrap_cnt_end", 64'(done_cnt_a), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_alu_pipe

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined integer ALU for the out-of-order core.
- Accepts one issued op per cycle from the ALU reservation station, tagged with its ROB index.
- Produces tagged results toward the common data bus with valid/ready backpressure.
- Supports flush on misprediction and the global ready (stall) signal.
- Adds branch-compare ops, selectable 1- or 2-stage latency, and a completed-op counter.

Parameters:
- XLEN, 32, operand/result width (power of two, >=8)
- ROB_WIDTH, 4, ROB tag width
- LATENCY, 1, pipeline stages (1 or 2); any other value is a compile-time error
- CNT_WIDTH, 16, width of completed-op counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; 0 freezes all state
- flush  in  1  kill all in-flight ops (qualified by rdy)
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_op  in  4  operation code
- in_a  in  XLEN  operand A
- in_b  in  XLEN  operand B
- in_tag  in  ROB_WIDTH  ROB index
- out_valid  out  1  result available
- out_ready  in  1  CDB accepts result
- out_result  out  XLEN  result
- out_tag  out  ROB_WIDTH  ROB index of result
- done_cnt  out  CNT_WIDTH  count of results accepted by the CDB (wraps)

Behaviour:
- Reset is asynchronous and active-low on reset. While reset is low: all stage valid bits are 0, out_valid=0, out_result=0, out_tag=0, done_cnt=0. Reset mid-operation discards all in-flight ops.
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 EQ, 11 NE, 12 GE (signed), 13 GEU. Codes 14–15 produce 0 and still complete with their tag.
- Compare ops (SLT, SLTU, EQ, NE, GE, GEU) return 1 or 0, zero-extended to XLEN.
- Shift amount is b[$clog2(XLEN)-1:0]. SRA is an arithmetic shift of A treated as signed. ADD/SUB wrap modulo 2^XLEN.
- Handshake: an op is accepted when rdy & in_valid & in_ready. A result is accepted when rdy & out_valid & out_ready.
- LATENCY=1: result is registered in the output stage at the accepting edge; out_valid is high the next cycle.
  - in_ready = rdy & (!out_valid | out_ready).
- LATENCY=2:
  - Stage 1 registers op, operands and tag.
  - Stage 2 computes and registers the result; out_valid is high 2 cycles after acceptance.
  - Stage 2 advances when it is empty or its result is accepted.
  - Stage 1 advances into stage 2 when stage 2 advances; bubbles are compressed.
  - in_ready = rdy & (stage 1 empty | stage 1 advancing).
- Throughput: 1 op/cycle whenever out_ready stays high.
- Stalls: while out_valid & !out_ready, out_result and out_tag are held stable.
- rdy=0: no state changes, in_ready=0, outputs held.
- flush (with rdy=1): all valid bits clear at the next edge.
  - An input presented in the same cycle is dropped.
  - A result accepted in the same cycle still counts in done_cnt.
  - in_ready is unaffected by flush itself.
- done_cnt increments by 1 per accepted result and wraps from 2^CNT_WIDTH-1 to 0.
- Simultaneous accept at input and output in a full pipe: both occur; occupancy is unchanged.

Decomposition:
- Shared package (alu_pkg):
  - op-code constants ALU_ADD..ALU_GEU
  - op width constant (4)
- Sub-module alu_core: purely combinational compute of result from op, a, b, parametrised by XLEN.
  - Instantiated once; placed before the output register (LATENCY=1) or between stage 1 and stage 2 (LATENCY=2).
- alu_pipe holds only pipeline registers, handshake logic and the counter.

Test Plan:
- Reset: hold reset low with in_valid=1 → out_valid=0, done_cnt=0, out_result=0; release → first op ADD 5,7 tag 3 gives out_result=12, out_tag=3 after LATENCY cycles.
- Op sweep, XLEN=32, a=0x80000000, b=1:
  - SUB→0x7FFFFFFF, SRA→0xC0000000, SRL→0x40000000
  - SLT→1, SLTU→0, GE→0, GEU→1
  - SLL with b=33 → 0x00000000 (shamt 1)
  - EQ 4,4→1, op 15→0
- Backpressure, LATENCY=2: stream tags 0..5 back-to-back with out_ready low for 3 cycles mid-stream → in_ready drops after the pipe fills, no op lost or duplicated, tag order preserved, done_cnt=6.
- Flush: two ops in flight plus a new in_valid, assert flush with rdy=1 → out_valid=0 next cycle, none of the three tags ever appear; the next op completes normally.
- rdy=0 for 4 cycles while out_valid=1 and out_ready=1 → outputs stable, done_cnt unchanged, in_ready=0; completes after rdy returns.
- Counter wrap, CNT_WIDTH=4: 17 accepted results → done_cnt=1.
